cmp_frame_scheduler: RTL and testbench
======================================

# cmp_frame_scheduler

Capture sequencer for the anti-probe front end. It runs in the `sample_clk` domain, after the three comparator sample registers (ref, S11, S21). On a start request it drives the common swing stimulus and packs comparator samples into framed 80-bit words for the GTH TX user-data port. Each frame is one header word, FRAME_LEN payload words and one tail word. A scope trigger pulse marks the start of each frame.

## Interface
Parameters:
- FRAME_LEN, 16 — payload words per frame; legal range 1..65535.
- SWING_HALF, 32 — `sample_clk` cycles per swing half-period; must be ≥1.

Ports:
- sample_clk  in  1  — single clock; every register is in this domain.
- reset  in  1  — asynchronous, active-high; clears all state.
- start  in  1  — level-sampled frame request; acted on only in IDLE.
- cmp_ref  in  1  — registered ref comparator sample.
- cmp_s11  in  1  — registered S11 comparator sample.
- cmp_s21  in  1  — registered S21 comparator sample.
- swing_out  out  1  — swing stimulus for S11, S21 and ref.
- trigger  out  1  — one-cycle pulse while the header word is presented.
- gth_data  out  80  — word to GTH TX; held between updates.
- gth_valid  out  1  — high for exactly one cycle when gth_data changes to a header, payload or tail word.
- busy  out  1  — high from HEADER through TAIL, inclusive.
- frame_cnt  out  16  — number of completed frames; wraps 16'hFFFF→0.

## Operation
- States: IDLE → HEADER → CAPTURE → TAIL → IDLE.
- IDLE:
  - gth_data = {10{8'hBC}} (fill word); gth_valid = 0; swing_out = 0.
  - start = 1 → HEADER.
- HEADER, 1 cycle:
  - gth_data = {16'hA5C3, frame_cnt, FRAME_LEN[15:0], 32'h0}.
  - gth_valid = 1; trigger = 1.
  - Next state CAPTURE.
- CAPTURE:
  - Each cycle, shift the triplet {cmp_ref, cmp_s11, cmp_s21} into a 78-bit packer. The first sample lands in [79:77], the 26th in [4:2].
  - After 26 samples, latch gth_data = {packed78, word_idx[1:0]} with gth_valid = 1.
  - The sample counter wraps 25→0 with no gap cycle.
  - word_idx counts 0..FRAME_LEN-1.
- Swing during CAPTURE:
  - swing_out starts at 0 in the first CAPTURE cycle.
  - It toggles every SWING_HALF cycles.
  - It is forced to 0 on exiting CAPTURE.
- End of CAPTURE: the edge that latches payload word FRAME_LEN-1 moves to TAIL.
- TAIL, 1 cycle:
  - gth_data = {16'h3C5A, frame_cnt, stats48}; gth_valid = 1.
  - On exit, frame_cnt increments and the state returns to IDLE.
- start while busy is ignored. It is not queued.
- Reset at any time, including mid-frame:
  - All state is cleared immediately.
  - Any partial frame is discarded.
  - frame_cnt returns to 0.

## Timing
- Reset values:
  - gth_data = fill word.
  - gth_valid = 0, trigger = 0, busy = 0, swing_out = 0.
  - frame_cnt = 0.
- start is high at edge E0. The header is visible after E0, and the first CAPTURE cycle follows E1.
- Payload word k (k = 0..FRAME_LEN-1) is visible after edge E1 + 26·(k+1).
- The tail is visible one cycle after the last payload word.
- The fill word returns one cycle after the tail.
- Total frame length is 26·FRAME_LEN + 2 gth words' worth of cycles: header + samples + tail.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- CMP_FRAME_STATS_EN defined:
  - stats48 = {ones_ref, ones_s11, ones_s21}, each 16 bits.
  - Each field counts the 1-samples that channel contributed to the frame's payload, saturating at 16'hFFFF.
  - The counters clear on entry to HEADER.
- CMP_FRAME_STATS_EN undefined:
  - stats48 = 48'h0.
  - The counters are not instantiated.

## Test plan
- Reset check: assert reset asynchronously → gth_data = BCBC…BC, gth_valid = 0, busy = 0, swing_out = 0, frame_cnt = 0, trigger = 0.
- Full frame: FRAME_LEN = 2, cmp_ref = 1, cmp_s11 = 0, cmp_s21 = 0, one-cycle start.
  - Header A5C3_0000_0002_00000000 with trigger = 1.
  - 26 cycles later, payload = {26{3'b100}, 2'b00}; 26 cycles after that, the same with idx 2'b01.
  - Then tail 3C5A_0000_…, then frame_cnt = 1.
- Swing: SWING_HALF = 4 → swing_out is 0,0,0,0,1,1,1,1,0… from the first CAPTURE cycle; it is 0 in HEADER, TAIL and IDLE.
- Busy rejection: pulse start again 10 cycles into CAPTURE → no new header; the frame ends after exactly 2 payload words; frame_cnt = 1.
- Mid-frame reset: assert reset mid-capture → all outputs return to reset values in the same cycle. The next start produces a header with frame_cnt field 0000.
- Stats option: FRAME_LEN = 2, cmp_s11 = 1, others 0.
  - With CMP_FRAME_STATS_EN: tail [47:0] = 0000_0034_0000.
  - Without it: tail [47:0] = 0.

Source files
------------

// File: rtl/cmp_frame_scheduler.sv
// cmp_frame_scheduler: capture sequencer that packs comparator samples into framed 80-bit GTH words
//
// Ports (all in the sample_clk domain, every output registered):
//   sample_clk  in   clock
//   reset       in   asynchronous active-high reset, clears all state
//   start       in   frame request, only acted on in IDLE
//   cmp_ref     in   registered ref comparator sample
//   cmp_s11     in   registered S11 comparator sample
//   cmp_s21     in   registered S21 comparator sample
//   swing_out   out  common swing stimulus, toggles every SWING_HALF cycles during CAPTURE
//   trigger     out  one-cycle scope pulse while the header word is presented
//   gth_data    out  80-bit word to GTH TX, held between updates
//   gth_valid   out  one-cycle strobe when gth_data takes a header, payload or tail word
//   busy        out  high from HEADER through TAIL
//   frame_cnt   out  completed frame count, wraps
//
// Optional feature: define CMP_FRAME_STATS_EN to fill the tail word with per-channel
// ones counts; otherwise the tail statistics field is zero and no counters exist.
module cmp_frame_scheduler #(
    parameter int FRAME_LEN  = 16,
    parameter int SWING_HALF = 32
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cmp_ref,
    input  logic        cmp_s11,
    input  logic        cmp_s21,
    output logic        swing_out,
    output logic        trigger,
    output logic [79:0] gth_data,
    output logic        gth_valid,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_HEADER   = 2'd1;
    localparam logic [1:0]  S_CAPTURE  = 2'd2;
    localparam logic [1:0]  S_TAIL     = 2'd3;
    localparam logic [79:0] FILL_WORD  = {10{8'hBC}};
    localparam logic [15:0] FRAME_LEN16 = 16'(FRAME_LEN);
    localparam logic [15:0] LAST_IDX   = 16'(FRAME_LEN - 1);
    localparam logic [31:0] SWING_LAST = 32'(SWING_HALF - 1);

    logic [1:0]  state_q, state_d;
    logic [79:0] gth_data_q, gth_data_d;
    logic        gth_valid_q, gth_valid_d;
    logic        trigger_q, trigger_d;
    logic        busy_q, busy_d;
    logic        swing_q, swing_d;
    logic [31:0] swing_cnt_q, swing_cnt_d;
    logic [4:0]  sample_cnt_q, sample_cnt_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    // Holds the 25 previous triplets; the 26th is taken straight from the inputs
    // on the latching edge, so the full 78-bit packer is {pack_q, triplet}.
    logic [74:0] pack_q, pack_d;
    logic [2:0]  triplet;
    logic [47:0] stats48;

    assign triplet = {cmp_ref, cmp_s11, cmp_s21};

`ifdef CMP_FRAME_STATS_EN
    logic [15:0] ones_ref_q, ones_ref_d;
    logic [15:0] ones_s11_q, ones_s11_d;
    logic [15:0] ones_s21_q, ones_s21_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic b);
        return (b && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        ones_ref_d = ones_ref_q;
        ones_s11_d = ones_s11_q;
        ones_s21_d = ones_s21_q;
        if (state_d == S_HEADER) begin
            ones_ref_d = '0;
            ones_s11_d = '0;
            ones_s21_d = '0;
        end else if (state_q == S_CAPTURE) begin
            ones_ref_d = sat_inc(ones_ref_q, cmp_ref);
            ones_s11_d = sat_inc(ones_s11_q, cmp_s11);
            ones_s21_d = sat_inc(ones_s21_q, cmp_s21);
        end
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            ones_ref_q <= '0;
            ones_s11_q <= '0;
            ones_s21_q <= '0;
        end else begin
            ones_ref_q <= ones_ref_d;
            ones_s11_q <= ones_s11_d;
            ones_s21_q <= ones_s21_d;
        end
    end

    assign stats48 = {ones_ref_q, ones_s11_q, ones_s21_q};
`else
    assign stats48 = 48'h0;
`endif

    always_comb begin
        state_d      = state_q;
        gth_data_d   = gth_data_q;
        gth_valid_d  = 1'b0;
        trigger_d    = 1'b0;
        swing_d      = swing_q;
        swing_cnt_d  = swing_cnt_q;
        sample_cnt_d = sample_cnt_q;
        word_idx_d   = word_idx_q;
        frame_cnt_d  = frame_cnt_q;
        pack_d       = pack_q;
        case (state_q)
            S_IDLE: begin
                gth_data_d = FILL_WORD;
                if (start) begin
                    state_d      = S_HEADER;
                    gth_data_d   = {16'hA5C3, frame_cnt_q, FRAME_LEN16, 32'h0};
                    gth_valid_d  = 1'b1;
                    trigger_d    = 1'b1;
                    sample_cnt_d = '0;
                    word_idx_d   = '0;
                end
            end
            S_HEADER: begin
                state_d     = S_CAPTURE;
                swing_d     = 1'b0;
                swing_cnt_d = '0;
            end
            S_CAPTURE: begin
                pack_d      = {pack_q[71:0], triplet};
                swing_d     = (swing_cnt_q == SWING_LAST) ? ~swing_q : swing_q;
                swing_cnt_d = (swing_cnt_q == SWING_LAST) ? '0 : swing_cnt_q + 32'd1;
                if (sample_cnt_q == 5'd25) begin
                    sample_cnt_d = '0;
                    gth_data_d   = {pack_q, triplet, word_idx_q[1:0]};
                    gth_valid_d  = 1'b1;
                    word_idx_d   = word_idx_q + 16'd1;
                    if (word_idx_q == LAST_IDX) begin
                        state_d     = S_TAIL;
                        swing_d     = 1'b0;
                        swing_cnt_d = '0;
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + 5'd1;
                end
            end
            default: begin
                // The tail word is emitted on the edge leaving TAIL, one cycle after the last payload word.
                state_d     = S_IDLE;
                gth_data_d  = {16'h3C5A, frame_cnt_q, stats48};
                gth_valid_d = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gth_data_q   <= FILL_WORD;
            gth_valid_q  <= 1'b0;
            trigger_q    <= 1'b0;
            busy_q       <= 1'b0;
            swing_q      <= 1'b0;
            swing_cnt_q  <= '0;
            sample_cnt_q <= '0;
            word_idx_q   <= '0;
            frame_cnt_q  <= '0;
            pack_q       <= '0;
        end else begin
            state_q      <= state_d;
            gth_data_q   <= gth_data_d;
            gth_valid_q  <= gth_valid_d;
            trigger_q    <= trigger_d;
            busy_q       <= busy_d;
            swing_q      <= swing_d;
            swing_cnt_q  <= swing_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            word_idx_q   <= word_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            pack_q       <= pack_d;
        end
    end

    assign swing_out = swing_q;
    assign trigger   = trigger_q;
    assign gth_data  = gth_data_q;
    assign gth_valid = gth_valid_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_cmp_frame_scheduler.sv
// tb_cmp_frame_scheduler: scoreboard bench for cmp_frame_scheduler with a frame-level reference model
module tb_cmp_frame_scheduler;
    localparam int FL = 2;
    localparam int SH = 4;
    localparam logic [79:0] FILL = {10{8'hBC}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        c_ref = 1'b0;
    logic        c_s11 = 1'b0;
    logic        c_s21 = 1'b0;
    logic        swing_out;
    logic        trigger;
    logic [79:0] gth_data;
    logic        gth_valid;
    logic        busy;
    logic [15:0] frame_cnt;

    typedef struct {
        logic [79:0] data;
        int          cyc;
        bit          hdr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] model_cnt = 16'd0;

    cmp_frame_scheduler #(.FRAME_LEN(FL), .SWING_HALF(SH)) dut (
        .sample_clk(clk),
        .reset(rst),
        .start(start),
        .cmp_ref(c_ref),
        .cmp_s11(c_s11),
        .cmp_s21(c_s21),
        .swing_out(swing_out),
        .trigger(trigger),
        .gth_data(gth_data),
        .gth_valid(gth_valid),
        .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input logic [79:0] d, input int c, input bit h);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        e.hdr  = h;
        exp_q.push_back(e);
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (gth_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected: got %h at cycle %0d, expected no word", gth_data, cyc);
                end else begin
                    exp_t e = exp_q.pop_front();
                    check("word_data", gth_data, e.data);
                    check("word_cycle", 80'(cyc), 80'(e.cyc));
                    check("word_trigger", 80'(trigger), 80'(e.hdr));
                end
            end else if (trigger !== 1'b0) begin
                check("stray_trigger", 80'(trigger), 80'd0);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data"}, gth_data, FILL);
        check({tag, "_valid"}, 80'(gth_valid), 80'd0);
        check({tag, "_busy"}, 80'(busy), 80'd0);
        check({tag, "_swing"}, 80'(swing_out), 80'd0);
        check({tag, "_trigger"}, 80'(trigger), 80'd0);
        check({tag, "_frame_cnt"}, 80'(frame_cnt), 80'd0);
    endtask

    // mode 0: random samples, 1: ref only, 2: s11 only.
    // reject: pulse start 10 cycles into capture. abort_at >= 0: reset at that capture cycle.
    task automatic run_frame(input int mode, input bit reject, input int abort_at);
        int          e0;
        logic [2:0]  s[$];
        logic [2:0]  t;
        logic [77:0] pw;
        logic [15:0] n_ref = 16'd0;
        logic [15:0] n_s11 = 16'd0;
        logic [15:0] n_s21 = 16'd0;
        logic [47:0] stats;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0 = cyc;
        push({16'hA5C3, model_cnt, 16'(FL), 32'h0}, e0, 1'b1);
        check("busy_header", 80'(busy), 80'd1);
        check("swing_header", 80'(swing_out), 80'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 26 * FL; i++) begin
            check("swing_capture", 80'(swing_out), 80'((i / SH) % 2));
            check("busy_capture", 80'(busy), 80'd1);
            if (i == abort_at) begin
                #1 rst = 1'b1;
                #1;
                check_reset("midreset");
                exp_q.delete();
                model_cnt = 16'd0;
                @(posedge clk);
                #1 rst = 1'b0;
                @(posedge clk);
                #1;
                check_reset("after_midreset");
                return;
            end
            t = (mode == 0) ? 3'($urandom) : (mode == 1) ? 3'b100 : 3'b010;
            {c_ref, c_s11, c_s21} = t;
            start = reject && (i == 10);
            s.push_back(t);
            n_ref += 16'(t[2]);
            n_s11 += 16'(t[1]);
            n_s21 += 16'(t[0]);
            if (i % 26 == 25) begin
                pw = '0;
                for (int j = i - 25; j <= i; j++) pw = {pw[74:0], s[j]};
                push({pw, 2'(i / 26)}, e0 + 1 + 26 * (i / 26 + 1), 1'b0);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("swing_tail", 80'(swing_out), 80'd0);
        check("busy_tail", 80'(busy), 80'd1);
`ifdef CMP_FRAME_STATS_EN
        stats = {n_ref, n_s11, n_s21};
`else
        stats = 48'h0;
`endif
        push({16'h3C5A, model_cnt, stats}, e0 + 2 + 26 * FL, 1'b0);
        @(posedge clk);
        #1;
        model_cnt++;
        check("frame_cnt", 80'(frame_cnt), 80'(model_cnt));
        @(posedge clk);
        #1;
        check("fill_after_tail", gth_data, FILL);
        check("busy_idle", 80'(busy), 80'd0);
        check("swing_idle", 80'(swing_out), 80'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset("idle");
        run_frame(1, 1'b0, -1);
        run_frame(2, 1'b0, -1);
        run_frame(0, 1'b1, -1);
        run_frame(0, 1'b0, 30);
        run_frame(1, 1'b0, -1);
        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_frame(0, f == 2, -1);
        end
        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 80'(exp_q.size()), 80'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
